// File: rtl/ps2_letter_decoder.sv
// PS/2 keyboard front end: receives 11-bit frames and turns letter, Enter and Backspace
// presses into single-cycle strobes. Release codes, extended keys and auto-repeat are dropped.
module ps2_letter_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [4:0] char,
  output logic       char_valid,
  output logic       enter_valid,
  output logic       bksp_valid,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    data_q, data_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          byte_ready_q, byte_ready_d, rx_err_q, rx_err_d;
  state_t        state_q, state_d;
  logic [7:0]    held_q, held_d;
  logic [4:0]    char_q, char_d;
  logic          char_valid_q, char_valid_d, enter_valid_q, enter_valid_d;
  logic          bksp_valid_q, bksp_valid_d, frame_err_q;
  logic          fall;
  logic [4:0]    letter;
  logic          is_key;

  function automatic logic [4:0] letter_of(input logic [7:0] code);
    case (code)
      8'h1C: letter_of = 5'd1;   8'h32: letter_of = 5'd2;   8'h21: letter_of = 5'd3;
      8'h23: letter_of = 5'd4;   8'h24: letter_of = 5'd5;   8'h2B: letter_of = 5'd6;
      8'h34: letter_of = 5'd7;   8'h33: letter_of = 5'd8;   8'h43: letter_of = 5'd9;
      8'h3B: letter_of = 5'd10;  8'h42: letter_of = 5'd11;  8'h4B: letter_of = 5'd12;
      8'h3A: letter_of = 5'd13;  8'h31: letter_of = 5'd14;  8'h44: letter_of = 5'd15;
      8'h4D: letter_of = 5'd16;  8'h15: letter_of = 5'd17;  8'h2D: letter_of = 5'd18;
      8'h1B: letter_of = 5'd19;  8'h2C: letter_of = 5'd20;  8'h3C: letter_of = 5'd21;
      8'h2A: letter_of = 5'd22;  8'h1D: letter_of = 5'd23;  8'h22: letter_of = 5'd24;
      8'h35: letter_of = 5'd25;  8'h1A: letter_of = 5'd26;
      default: letter_of = 5'd0;
    endcase
  endfunction

  assign fall = clk_prev_q & ~clk_s2_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q     <= 1'b0;
      clk_s2_q     <= 1'b0;
      clk_prev_q   <= 1'b0;
      dat_s1_q     <= 1'b0;
      dat_s2_q     <= 1'b0;
      bit_cnt_q    <= '0;
      data_q       <= '0;
      parity_q     <= 1'b0;
      timer_q      <= '0;
      byte_ready_q <= 1'b0;
      rx_err_q     <= 1'b0;
    end else begin
      clk_s1_q     <= ps2_clk;
      clk_s2_q     <= clk_s1_q;
      clk_prev_q   <= clk_s2_q;
      dat_s1_q     <= ps2_dat;
      dat_s2_q     <= dat_s1_q;
      bit_cnt_q    <= bit_cnt_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      timer_q      <= timer_d;
      byte_ready_q <= byte_ready_d;
      rx_err_q     <= rx_err_d;
    end
  end

  // Bit 0 is the start bit; a high start bit is treated as line noise and ignored.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    data_d       = data_q;
    parity_d     = parity_q;
    timer_d      = '0;
    byte_ready_d = 1'b0;
    rx_err_d     = 1'b0;
    if (fall) begin
      case (bit_cnt_q)
        4'd0: if (!dat_s2_q) bit_cnt_d = 4'd1;
        4'd9: begin
          parity_d  = dat_s2_q;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (dat_s2_q && (^{data_q, parity_q})) byte_ready_d = 1'b1;
          else                                   rx_err_d     = 1'b1;
        end
        default: begin
          data_d    = {dat_s2_q, data_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      if (timer_q == TIMEOUT_LAST) begin
        bit_cnt_d = 4'd0;
        rx_err_d  = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      held_q        <= '0;
      char_q        <= '0;
      char_valid_q  <= 1'b0;
      enter_valid_q <= 1'b0;
      bksp_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      char_q        <= char_d;
      char_valid_q  <= char_valid_d;
      enter_valid_q <= enter_valid_d;
      bksp_valid_q  <= bksp_valid_d;
      frame_err_q   <= rx_err_q;
    end
  end

  assign letter = letter_of(data_q);
  assign is_key = (letter != 5'd0) || (data_q == 8'h5A) || (data_q == 8'h66);

  always_comb begin
    state_d = state_q;
    if (byte_ready_q) begin
      case (state_q)
        IDLE: begin
          if (data_q == 8'hF0)      state_d = BRK;
          else if (data_q == 8'hE0) state_d = EXT;
        end
        EXT:     state_d = (data_q == 8'hF0) ? EXT_BRK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A make code matching the held key is typematic repeat and is swallowed.
  always_comb begin
    held_d        = held_q;
    char_d        = char_q;
    char_valid_d  = 1'b0;
    enter_valid_d = 1'b0;
    bksp_valid_d  = 1'b0;
    if (byte_ready_q) begin
      if (state_q == IDLE && is_key && data_q != held_q) begin
        held_d = data_q;
        if (letter != 5'd0) begin
          char_d       = letter;
          char_valid_d = 1'b1;
        end else if (data_q == 8'h5A) begin
          enter_valid_d = 1'b1;
        end else begin
          bksp_valid_d = 1'b1;
        end
      end else if (state_q == BRK && data_q == held_q) begin
        held_d = '0;
      end
    end
  end

  assign char        = char_q;
  assign char_valid  = char_valid_q;
  assign enter_valid = enter_valid_q;
  assign bksp_valid  = bksp_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Directed bench for ps2_letter_decoder: drives PS/2 frames bit by bit and checks strobes,
// latency, repeat suppression, error handling and reset behaviour.
module tb_ps2_letter_decoder;

  localparam int TIMEOUT = 50000;
  localparam int HALF    = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [4:0] char;
  logic       char_valid, enter_valid, bksp_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_char = 0, n_enter = 0, n_bksp = 0, n_err = 0, n_multi = 0;
  int last_cv_cyc = 0, last_err_cyc = 0;
  int last_fall_cyc = 0;

  ps2_letter_decoder #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .char(char), .char_valid(char_valid), .enter_valid(enter_valid),
    .bksp_valid(bksp_valid), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (char_valid)  begin n_char  <= n_char + 1;  last_cv_cyc  <= cyc; end
    if (enter_valid) n_enter <= n_enter + 1;
    if (bksp_valid)  n_bksp  <= n_bksp + 1;
    if (frame_err)   begin n_err <= n_err + 1; last_err_cyc <= cyc; end
    if (int'(char_valid) + int'(enter_valid) + int'(bksp_valid) + int'(frame_err) > 1)
      n_multi <= n_multi + 1;
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad);
    logic par;
    par = (~^b) ^ bad;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1 ps2_dat = bits[i];
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(posedge clk);
      #1 ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad);
    send_bits(mk(b, bad), 11);
    repeat (20) @(posedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset;
    #5 resetn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({char, char_valid, enter_valid, bksp_valid, frame_err} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0", {char, char_valid, enter_valid, bksp_valid, frame_err});
    end
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    $display("reset: char=%0d", char);
  endtask

  task automatic test_make_break;
    int c0, stop_cyc;
    c0 = n_char;
    send_bits(mk(8'h1C, 1'b0), 11);
    stop_cyc = last_fall_cyc;
    repeat (20) @(posedge clk);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    #1;
    chk("make_break_count", n_char - c0, 1);
    chk("make_break_latency", last_cv_cyc - stop_cyc, 4);
    chk("make_break_char", int'(char), 1);
    $display("make_break: char=%0d pulses=%0d", char, n_char - c0);
  endtask

  task automatic test_typematic;
    int c0;
    c0 = n_char;
    send_frame(8'h1A, 1'b0);
    #1 chk("repeat_first_char", int'(char), 26);
    send_frame(8'h1A, 1'b0);
    send_frame(8'h1A, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1A, 1'b0);
    chk("repeat_mid_count", n_char - c0, 1);
    send_frame(8'h1A, 1'b0);
    #1;
    chk("repeat_count", n_char - c0, 2);
    chk("repeat_char", int'(char), 26);
    $display("typematic: char=%0d pulses=%0d", char, n_char - c0);
  endtask

  task automatic test_parity;
    int c0, e0, stop_cyc;
    c0 = n_char; e0 = n_err;
    send_bits(mk(8'h35, 1'b1), 11);
    stop_cyc = last_fall_cyc;
    repeat (20) @(posedge clk);
    #1;
    chk("parity_err_count", n_err - e0, 1);
    chk("parity_err_latency", last_err_cyc - stop_cyc, 4);
    chk("parity_no_char", n_char - c0, 0);
    chk("parity_char_kept", int'(char), 26);
    send_frame(8'h35, 1'b0);
    #1;
    chk("parity_recover_char", int'(char), 25);
    chk("parity_recover_count", n_char - c0, 1);
    $display("parity: err=%0d char=%0d", n_err - e0, char);
  endtask

  task automatic test_timeout;
    int e0, n0, fall_cyc;
    e0 = n_err; n0 = n_enter;
    send_bits(mk(8'h5A, 1'b0), 4);
    fall_cyc = last_fall_cyc;
    while (cyc < fall_cyc + TIMEOUT + 2) @(posedge clk);
    #1 chk("timeout_not_early", n_err - e0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("timeout_err_count", n_err - e0, 1);
    chk("timeout_err_cycle", last_err_cyc - fall_cyc, TIMEOUT + 4);
    send_frame(8'h5A, 1'b0);
    #1;
    chk("timeout_enter", n_enter - n0, 1);
    chk("timeout_char_kept", int'(char), 25);
    chk("timeout_no_extra_err", n_err - e0, 1);
    $display("timeout: err=%0d enter=%0d", n_err - e0, n_enter - n0);
  endtask

  task automatic test_extended;
    int c0, n0, b0;
    c0 = n_char; n0 = n_enter; b0 = n_bksp;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    send_frame(8'h66, 1'b0);
    #1;
    chk("ext_enter_none", n_enter - n0, 0);
    chk("ext_char_none", n_char - c0, 0);
    chk("ext_bksp", n_bksp - b0, 1);
    chk("ext_char_kept", int'(char), 25);
    $display("extended: bksp=%0d enter=%0d char=%0d", n_bksp - b0, n_enter - n0, char);
  endtask

  task automatic test_reset_midframe;
    int c0, e0, n0, b0;
    send_bits(mk(8'h24, 1'b0), 7);
    @(posedge clk); #1 resetn = 1'b0;
    #1;
    chk("midreset_char", int'(char), 0);
    chk("midreset_strobes", int'({char_valid, enter_valid, bksp_valid, frame_err}), 0);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b1;
    c0 = n_char; e0 = n_err; n0 = n_enter; b0 = n_bksp;
    repeat (300) @(posedge clk);
    #1;
    chk("midreset_quiet", (n_char - c0) + (n_err - e0) + (n_enter - n0) + (n_bksp - b0), 0);
    send_frame(8'h24, 1'b0);
    #1;
    chk("midreset_char_e", int'(char), 5);
    chk("midreset_count", n_char - c0, 1);
    chk("midreset_no_err", n_err - e0, 0);
    $display("reset_midframe: char=%0d", char);
  endtask

  initial begin
    test_reset;
    test_make_break;
    test_typematic;
    test_parity;
    test_timeout;
    test_extended;
    test_reset_midframe;
    chk("single_strobe", n_multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_letter_decoder.md
Name: ps2_letter_decoder

Overview:
- Upstream input stage of the hangman datapath: receives raw PS/2 keyboard frames and converts letter key presses into the 5-bit char/guess codes the datapath consumes.
- Also reports Enter and Backspace presses to the control FSM.
- Suppresses key-release codes, extended-key codes and typematic auto-repeat, so each physical key press yields exactly one strobe.

Parameters:
- TIMEOUT_CYCLES, 50000: idle clk cycles within a partial frame before the receiver abandons it (1 ms at 50 MHz).

Ports:
- clk  input  1  system clock (50 MHz)
- resetn  input  1  asynchronous active-low reset
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk
- ps2_dat  input  1  raw PS/2 data pin, asynchronous to clk
- char  output  5  last accepted letter: A=1 … Z=26; 0 = none since reset
- char_valid  output  1  one-cycle strobe; char updated the same cycle
- enter_valid  output  1  one-cycle strobe on Enter press
- bksp_valid  output  1  one-cycle strobe on Backspace press
- frame_err  output  1  one-cycle strobe on parity, stop or timeout error

Behaviour:
Reset:
- All outputs go to 0; synchronisers, bit counter, shift register and decode FSM clear.
- Held-key register clears to 0.
- Reset mid-frame discards the partial frame; no strobe is emitted on release.

Receiver:
- ps2_clk and ps2_dat each pass through 2 flip-flops.
- A falling edge is detected when the synchronised clk was 1 last cycle and is 0 this cycle; ps2_dat is sampled on that cycle.
- Frame is 11 bits: start(0), d0..d7 (LSB first), odd parity, stop(1). Bit counter runs 0..10.
- Start bit sampled as 1: ignored, counter stays 0, no error.
- Bad parity or stop=0 at bit 10: frame_err pulses, byte is dropped, counter returns to 0.
- Timeout: if counter is nonzero and no falling edge arrives for TIMEOUT_CYCLES consecutive cycles, the counter resets to 0 and frame_err pulses.
- A good frame raises byte_ready (internal) for 1 cycle, 1 cycle after the stop-bit edge cycle.

Decode FSM, advanced only on byte_ready:
- IDLE:
  - F0 -> BRK
  - E0 -> EXT
  - letter scan code -> emit letter
  - 5A -> enter_valid
  - 66 -> bksp_valid
  - any other code ignored
- BRK: any code -> IDLE, nothing emitted. If the code equals the held key, held key clears to 0.
- EXT: F0 -> EXT_BRK; any other code -> IDLE, nothing emitted (keypad Enter and arrows are ignored).
- EXT_BRK: any code -> IDLE, nothing emitted.

Emit rule (letters, Enter, Backspace):
- A make code equal to the held key is a typematic repeat and is suppressed.
- Otherwise the strobe asserts and held key <= scan code.
- A new key while another is held is accepted and replaces the held key.

Letter map (set 2, code = alphabet index):
- 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F, 34=G, 33=H, 43=I, 3B=J, 42=K, 4B=L, 3A=M
- 31=N, 44=O, 4D=P, 15=Q, 2D=R, 1B=S, 2C=T, 3C=U, 2A=V, 1D=W, 22=X, 35=Y, 1A=Z

Timing and hold:
- Strobes are registered and assert exactly 2 clk cycles after the synchronised stop-bit falling-edge cycle. At most one strobe is active per cycle.
- char holds its value until the next accepted letter; Enter and Backspace do not alter char.
- frame_err may coincide with no other strobe, since an error frame produces no byte.

Test Plan:
1. Frames 1C, F0, 1C -> one char_valid with char=1, 2 cycles after the first stop-bit edge; the break frames emit nothing; char stays 1.
2. Frames 1A, 1A, 1A (repeat), F0, 1A, then 1A -> exactly 2 char_valid pulses, char=26 both times.
3. Frame 35 with wrong parity -> frame_err pulse, no char_valid; a following good 35 -> char=25.
4. 4 bits of a frame, then ps2_clk idle for 50000 cycles -> frame_err pulse at cycle 50000; a following good 5A frame -> enter_valid and receiver in sync.
5. Frames E0, 5A, E0, F0, 5A, then 66 -> only bksp_valid pulses; char unchanged.
6. resetn low mid-frame, after bit 6 of frame 24 -> all outputs 0 immediately; releasing reset and sending a full 24 frame -> char=5.
